// File: rtl/ps2_mouse_pkg.sv
// Shared types and field positions for the PS/2 mouse receiver.
// Receive-state encoding, packet geometry and ps2_mouse word layout.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int PKT_BYTES = 3;
  localparam int SYNC_BIT  = 3;

  localparam int TOGGLE = 24;
  localparam int DY_HI  = 23;
  localparam int DY_LO  = 16;
  localparam int DX_HI  = 15;
  localparam int DX_LO  = 8;
  localparam int BTN_L  = 0;
  localparam int BTN_R  = 1;

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device->host byte receiver: pin synchronisers, clock glitch filter, bit FSM, bit timeout.
// Build option PS2_PARITY_CHECK_EN: drop bytes whose odd parity does not match.
module ps2_rx_byte
  import ps2_mouse_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err,
  output logic       rx_busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic          r_clk_filt_d;
  logic [FW-1:0] r_filt_cnt;
  rx_state_e     r_state;
  rx_state_e     w_state_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic          r_byte_valid;
  logic [7:0]    r_byte_data;
  logic          r_err;
  logic          w_dat;
  logic          w_fall;
  logic          w_timeout;
  logic          w_par_ok;
  logic          w_valid_set;
  logic          w_err_set;

  // Pins idle high, so the synchronisers reset to 1 to avoid a phantom edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
      r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
    end
  end

  assign w_dat = r_dat_sync[1];

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall    = r_clk_filt_d & ~r_clk_filt;
  assign w_timeout = (r_state != RX_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES));
  assign rx_busy   = (r_state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (reset || r_state == RX_IDLE || w_fall) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic r_par_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_bit <= 1'b0;
    end else if (w_fall && r_state == RX_PARITY) begin
      r_par_bit <= w_dat;
    end
  end

  assign w_par_ok = ^{r_shift, r_par_bit};
`else
  assign w_par_ok = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_valid_set  = 1'b0;
    w_err_set    = 1'b0;
    if (w_timeout) begin
      w_state_next = RX_IDLE;
      w_err_set    = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        RX_IDLE:   if (!w_dat) w_state_next = RX_DATA;
        RX_DATA:   if (r_bit_cnt == 3'd7) w_state_next = RX_PARITY;
        RX_PARITY: w_state_next = RX_STOP;
        RX_STOP: begin
          w_state_next = RX_IDLE;
          if (w_dat && w_par_ok) w_valid_set = 1'b1;
          else                   w_err_set   = 1'b1;
        end
        default:   w_state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_byte_valid <= w_valid_set;
      r_err        <= w_err_set;
      if (w_valid_set) r_byte_data <= r_shift;
      if (w_fall && !w_timeout) begin
        if (r_state == RX_IDLE) begin
          r_bit_cnt <= '0;
        end else if (r_state == RX_DATA) begin
          r_shift   <= {w_dat, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign err        = r_err;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: byte receiver plus 3-byte packet assembler with inter-byte timeout.
// Build option PS2_PARITY_CHECK_EN is honoured inside ps2_rx_byte.
module ps2_mouse_rx
  import ps2_mouse_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [24:0] ps2_mouse,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          w_byte_valid;
  logic [7:0]    w_byte_data;
  logic          w_err;
  logic          w_rx_busy;
  logic          w_gap_to;
  logic [1:0]    r_idx;
  logic [7:0]    r_b0;
  logic [7:0]    r_b1;
  logic [TW-1:0] r_gap_cnt;
  logic [24:0]   r_mouse;

  ps2_rx_byte #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx_byte (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .err        (w_err),
    .rx_busy    (w_rx_busy)
  );

  // The gap timer runs only while the line is idle, since a single frame outlasts the timeout.
  assign w_gap_to = (r_idx != 2'd0) && (r_gap_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_gap_cnt <= '0;
      r_mouse   <= '0;
    end else begin
      if (w_err || w_byte_valid || w_rx_busy || r_idx == 2'd0) begin
        r_gap_cnt <= '0;
      end else if (!w_gap_to) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end

      if (w_err || w_gap_to) begin
        r_idx <= '0;
      end else if (w_byte_valid) begin
        if (r_idx == 2'd0) begin
          if (w_byte_data[SYNC_BIT]) begin
            r_b0  <= w_byte_data;
            r_idx <= 2'd1;
          end
        end else if (r_idx != 2'(PKT_BYTES - 1)) begin
          r_b1  <= w_byte_data;
          r_idx <= r_idx + 1'b1;
        end else begin
          r_mouse[TOGGLE]      <= ~r_mouse[TOGGLE];
          r_mouse[DY_HI:DY_LO] <= w_byte_data;
          r_mouse[DX_HI:DX_LO] <= r_b1;
          r_mouse[DX_LO-1:0]   <= r_b0;
          r_idx                <= '0;
        end
      end
    end
  end

  assign ps2_mouse  = r_mouse;
  assign byte_valid = w_byte_valid;
  assign byte_data  = w_byte_data;
  assign err        = w_err;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Scoreboard bench for ps2_mouse_rx: stimulus pushes expected bytes/packets, monitor pops on output events.
// Parity expectations follow PS2_PARITY_CHECK_EN.
module tb_ps2_mouse_rx;

  localparam int FILTER_LEN = 2;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 40;
  localparam int GAP        = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [24:0] ps2_mouse;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        err;

  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;
  int          e0;
  logic [24:0] exp_pkt_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [24:0] prev_mouse = '0;

  always #5 clk = ~clk;

  ps2_mouse_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_mouse  (ps2_mouse),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each presented byte and each ps2_mouse change against the queues.
  always @(negedge clk) begin
    if (err) err_seen++;
    if (byte_valid) begin
      if (exp_byte_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL byte_unexpected: got %0h expected none", byte_data);
      end else begin
        check("byte", {24'd0, byte_data}, {24'd0, exp_byte_q.pop_front()});
      end
    end
    if (ps2_mouse !== prev_mouse) begin
      if (exp_pkt_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pkt_unexpected: got %0h expected none", ps2_mouse);
      end else begin
        check("packet", {7'd0, ps2_mouse}, {7'd0, exp_pkt_q.pop_front()});
      end
      prev_mouse = ps2_mouse;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int stall_after = 0,
                            input bit glitch = 1'b0);
    logic [10:0] bits;
    int          n;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    n    = (stall_after > 0) ? stall_after : 11;
    for (int i = 0; i < n; i++) begin
      ps2_dat_in = bits[i];
      if (glitch && (i == 3 || i == 6)) begin
        tick(HALF / 2);
        ps2_clk_in = 1'b0;
        tick(1);
        ps2_clk_in = 1'b1;
        tick(HALF / 2 - 1);
      end else begin
        tick(HALF);
      end
      ps2_clk_in = 1'b0;
      tick(HALF);
      ps2_clk_in = 1'b1;
    end
    ps2_dat_in = 1'b1;
    tick((stall_after > 0) ? 500 : GAP);
  endtask

  task automatic send_byte(input logic [7:0] d);
    exp_byte_q.push_back(d);
    send_frame(d);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_mouse", {7'd0, ps2_mouse}, 32'd0);
    check("rst_byte_data", {24'd0, byte_data}, 32'd0);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Basic packets; toggle alternates
    exp_pkt_q.push_back(25'h1_FB_05_09);
    send_byte(8'h09); send_byte(8'h05); send_byte(8'hFB);
    exp_pkt_q.push_back(25'h0_00_00_08);
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);

    // First byte without sync bit is dropped
    send_byte(8'h01);
    exp_pkt_q.push_back(25'h1_20_10_0A);
    send_byte(8'h0A); send_byte(8'h10); send_byte(8'h20);

    // Bad parity on a first byte
    e0 = err_seen;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h09, 1'b1);
    check("parity_err", err_seen, e0 + 1);
    exp_pkt_q.push_back(25'h0_22_11_0B);
    send_byte(8'h0B); send_byte(8'h11); send_byte(8'h22);
`else
    exp_pkt_q.push_back(25'h0_11_0B_09);
    exp_byte_q.push_back(8'h09);
    send_frame(8'h09, 1'b1);
    check("parity_ignored", err_seen, e0);
    send_byte(8'h0B); send_byte(8'h11); send_byte(8'h22);
`endif

    // Stop bit 0 mid-packet: err, packet restarts
    send_byte(8'h09);
    e0 = err_seen;
    send_frame(8'h55, 1'b0, 1'b1);
    check("stop_err", err_seen, e0 + 1);
    exp_pkt_q.push_back(25'h1_44_33_0C);
    send_byte(8'h0C); send_byte(8'h33); send_byte(8'h44);

    // Frame stalled after 5 bits mid-packet
    send_byte(8'h09);
    e0 = err_seen;
    send_frame(8'h77, 1'b0, 1'b0, 5);
    check("timeout_err", err_seen, e0 + 1);
    exp_pkt_q.push_back(25'h0_02_01_18);
    send_byte(8'h18); send_byte(8'h01); send_byte(8'h02);

    // Reset mid-packet
    send_byte(8'h08); send_byte(8'h7F);
    exp_pkt_q.push_back(25'h0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    check("rst2_mouse", {7'd0, ps2_mouse}, 32'd0);
    exp_pkt_q.push_back(25'h1_02_01_28);
    send_byte(8'h28); send_byte(8'h01); send_byte(8'h02);

    // Inter-byte gap timeout: silent idx reset
    e0 = err_seen;
    send_byte(8'h08); send_byte(8'h03);
    tick(500);
    exp_pkt_q.push_back(25'h0_05_04_38);
    send_byte(8'h38); send_byte(8'h04); send_byte(8'h05);
    check("gap_no_err", err_seen, e0);

    // Clock glitches inside bits
    exp_byte_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b1);

    tick(50);
    check("pkt_q_empty", exp_pkt_q.size(), 32'd0);
    check("byte_q_empty", exp_byte_q.size(), 32'd0);
`ifdef PS2_PARITY_CHECK_EN
    check("err_total", err_seen, 32'd3);
`else
    check("err_total", err_seen, 32'd2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
